// File: rtl/fft_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fft_ctrl_pkg
// Shared types and helpers for the FFT pipeline stage controllers.
//   ctrl_state_e : sequencer state (IDLE / RUN / FLUSH)
//   clog2_min1() : ceil(log2(value)), never less than 1, for sizing index ports
// -----------------------------------------------------------------------------
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } ctrl_state_e;

  // A span of 1 still needs a 1-bit index port, so clamp the width at 1.
  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/bfly_stage_ctrl.sv
// -----------------------------------------------------------------------------
// bfly_stage_ctrl
// Sequencer for one radix-2 single-delay-feedback butterfly stage. Counts input
// beats per frame and drives the delay line, the butterfly/bypass mux and the
// twiddle selection, plus output valid / frame markers for the CBFP block.
//
// Parameters
//   FRAME_BEATS : beats per frame (power of two)
//   SPAN        : butterfly span in beats (power of two, 1..FRAME_BEATS/2)
//   TW_W        : twiddle index width
// Ports
//   clk, rstn   : stage clock, asynchronous active-low reset
//   din_valid   : input beat strobe
//   err_clr     : clears err_gap
//   dly_en      : delay-line shift enable
//   mux_sel     : 1 = butterfly, 0 = bypass
//   tw_en       : apply twiddle to the current output beat
//   tw_idx      : twiddle index within span
//   dout_valid  : stage output beat valid
//   dout_sof    : first output beat of a frame
//   dout_eof    : last output beat of a frame
//   busy        : frame in progress (input or flush)
//   err_gap     : sticky, din_valid dropped mid-frame
// All outputs are registered: controls for a beat sampled at one edge are
// presented during the following cycle, aligned with the datapath input reg.
// -----------------------------------------------------------------------------
module bfly_stage_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int FRAME_BEATS = 32,
  parameter int SPAN        = 2,
  parameter int TW_W        = clog2_min1(SPAN)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            din_valid,
  input  logic            err_clr,
  output logic            dly_en,
  output logic            mux_sel,
  output logic            tw_en,
  output logic [TW_W-1:0] tw_idx,
  output logic            dout_valid,
  output logic            dout_sof,
  output logic            dout_eof,
  output logic            busy,
  output logic            err_gap
);

  localparam int K_W = clog2_min1(FRAME_BEATS);

  localparam logic [K_W-1:0]  K_LAST    = K_W'(FRAME_BEATS - 1);
  localparam logic [K_W-1:0]  K_SPAN    = K_W'(SPAN);
  localparam logic [K_W-1:0]  K_MASK    = K_W'(SPAN - 1);
  // One extra bit: 2*SPAN may equal FRAME_BEATS, which does not fit in K_W.
  localparam logic [K_W:0]    TWO_SPAN  = (K_W + 1)'(2 * SPAN);
  localparam logic [TW_W-1:0] F_LAST    = TW_W'(SPAN - 1);

  // Sequencing state
  ctrl_state_e     state_q, state_d;
  logic [K_W-1:0]  k_q, k_d;      // index of the next input beat in the frame
  logic [TW_W-1:0] f_q, f_d;      // index of the next pending diff to emit
  logic            pend_q, pend_d; // previous frame still has diffs in the delay

  // Output registers
  logic            dly_en_q, dly_en_d;
  logic            mux_sel_q, mux_sel_d;
  logic            tw_en_q, tw_en_d;
  logic [TW_W-1:0] tw_idx_q, tw_idx_d;
  logic            dout_valid_q, dout_valid_d;
  logic            dout_sof_q, dout_sof_d;
  logic            dout_eof_q, dout_eof_d;
  logic            busy_q, busy_d;
  logic            err_gap_q, err_gap_d;

  // Per-cycle decode
  logic beat;       // an input beat is accepted this cycle
  logic emit;       // a pending diff of the previous frame leaves the delay
  logic gap;        // din_valid dropped inside a frame
  logic calc;       // accepted beat falls in a CALC phase
  logic fill_diff;  // accepted FILL beat that outputs this frame's stored diff

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    k_d          = k_q;
    f_d          = f_q;
    pend_d       = pend_q;
    dly_en_d     = 1'b0;
    mux_sel_d    = 1'b0;
    tw_en_d      = 1'b0;
    tw_idx_d     = '0;
    dout_valid_d = 1'b0;
    dout_sof_d   = 1'b0;
    dout_eof_d   = 1'b0;

    // k_q is 0 whenever a new frame may start, so a beat always uses k_q.
    // In RUN with k_q == 0 the previous frame has just completed, so a
    // missing beat there is the start of the flush rather than a gap.
    gap  = (state_q == RUN) && (k_q != '0) && !din_valid;
    beat = din_valid;
    emit = pend_q && !gap;

    // floor(k/SPAN) is odd exactly when the SPAN bit of k is set.
    calc      = beat && ((k_q & K_SPAN) != '0);
    fill_diff = beat && !calc && ({1'b0, k_q} >= TWO_SPAN);

    if (emit) begin
      if (f_q == F_LAST) begin
        pend_d = 1'b0;
        f_d    = '0;
      end else begin
        f_d = f_q + TW_W'(1);
      end
    end

    // A frame wrap can never overlap an emit: pending diffs of the previous
    // frame are gone by beat SPAN-1 of the next one.
    if (beat) begin
      if (k_q == K_LAST) begin
        k_d    = '0;
        pend_d = 1'b1;
        f_d    = '0;
      end else begin
        k_d = k_q + K_W'(1);
      end
    end

    if (gap) begin
      k_d    = '0;
      f_d    = '0;
      pend_d = 1'b0;
    end

    if (gap)         state_d = IDLE;
    else if (beat)   state_d = RUN;
    else if (pend_d) state_d = FLUSH;
    else             state_d = IDLE;

    dly_en_d     = beat || emit;
    mux_sel_d    = calc;
    dout_valid_d = calc || fill_diff || emit;
    tw_en_d      = fill_diff || emit;
    dout_sof_d   = calc && (k_q == K_SPAN);
    dout_eof_d   = emit && (f_q == F_LAST);
    if (emit)           tw_idx_d = f_q;
    else if (fill_diff) tw_idx_d = TW_W'(k_q & K_MASK);

    busy_d    = beat || emit;
    // A gap in the same cycle as err_clr keeps the flag set.
    err_gap_d = gap || (err_gap_q && !err_clr);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      k_q          <= '0;
      f_q          <= '0;
      pend_q       <= 1'b0;
      dly_en_q     <= 1'b0;
      mux_sel_q    <= 1'b0;
      tw_en_q      <= 1'b0;
      tw_idx_q     <= '0;
      dout_valid_q <= 1'b0;
      dout_sof_q   <= 1'b0;
      dout_eof_q   <= 1'b0;
      busy_q       <= 1'b0;
      err_gap_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      f_q          <= f_d;
      pend_q       <= pend_d;
      dly_en_q     <= dly_en_d;
      mux_sel_q    <= mux_sel_d;
      tw_en_q      <= tw_en_d;
      tw_idx_q     <= tw_idx_d;
      dout_valid_q <= dout_valid_d;
      dout_sof_q   <= dout_sof_d;
      dout_eof_q   <= dout_eof_d;
      busy_q       <= busy_d;
      err_gap_q    <= err_gap_d;
    end
  end

  assign dly_en     = dly_en_q;
  assign mux_sel    = mux_sel_q;
  assign tw_en      = tw_en_q;
  assign tw_idx     = tw_idx_q;
  assign dout_valid = dout_valid_q;
  assign dout_sof   = dout_sof_q;
  assign dout_eof   = dout_eof_q;
  assign busy       = busy_q;
  assign err_gap    = err_gap_q;

endmodule

// File: tb/tb_bfly_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bfly_stage_ctrl
// Two controllers (SPAN=4 and SPAN=1, FRAME_BEATS=32) share clock, reset and
// input strobes. A frame-level model schedules every expected output beat into
// a per-cycle table: CALC beats and late FILL beats produce an output one cycle
// after they are sampled, and a completed frame books its SPAN trailing diffs
// on the following cycles. Aborts and resets cancel whatever is still booked.
// -----------------------------------------------------------------------------
module tb_bfly_stage_ctrl;

  localparam int FB      = 32;
  localparam int CYC_MAX = 8192;

  typedef struct packed {
    logic       dly_en;
    logic       mux_sel;
    logic       tw_en;
    logic [3:0] tw_idx;
    logic       dout_valid;
    logic       dout_sof;
    logic       dout_eof;
    logic       busy;
    logic       err_gap;
  } obs_t;

  logic clk;
  logic rstn;
  logic din_valid;
  logic err_clr;

  logic       dly_en4, mux_sel4, tw_en4, dout_valid4, dout_sof4, dout_eof4, busy4, err_gap4;
  logic [1:0] tw_idx4;
  logic       dly_en1, mux_sel1, tw_en1, dout_valid1, dout_sof1, dout_eof1, busy1, err_gap1;
  logic [0:0] tw_idx1;

  bfly_stage_ctrl #(.FRAME_BEATS(FB), .SPAN(4)) u_dut4 (
    .clk(clk), .rstn(rstn), .din_valid(din_valid), .err_clr(err_clr),
    .dly_en(dly_en4), .mux_sel(mux_sel4), .tw_en(tw_en4), .tw_idx(tw_idx4),
    .dout_valid(dout_valid4), .dout_sof(dout_sof4), .dout_eof(dout_eof4),
    .busy(busy4), .err_gap(err_gap4)
  );

  bfly_stage_ctrl #(.FRAME_BEATS(FB), .SPAN(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .din_valid(din_valid), .err_clr(err_clr),
    .dly_en(dly_en1), .mux_sel(mux_sel1), .tw_en(tw_en1), .tw_idx(tw_idx1),
    .dout_valid(dout_valid1), .dout_sof(dout_sof1), .dout_eof(dout_eof1),
    .busy(busy1), .err_gap(err_gap1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bookkeeping
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;   // number of rising edges seen so far
  int   base  = 0;   // edge index at which the current scenario's beat 0 is sampled

  obs_t exp_q [2][CYC_MAX];
  obs_t act4  [CYC_MAX];
  obs_t act1  [CYC_MAX];

  // Frame-level model state
  bit   m_active = 1'b0;
  int   m_k      = 0;
  bit   m_err    = 1'b0;

  function automatic int span_of(input int s);
    return (s == 0) ? 4 : 1;
  endfunction

  // Output-table index for "cycle c" counted from beat 0 being in cycle 0.
  function automatic int pc(input int c);
    return base + c - 1;
  endfunction

  function automatic obs_t beat_out(input int span, input int idx);
    obs_t o;
    o        = '0;
    o.dly_en = 1'b1;
    o.busy   = 1'b1;
    if (((idx / span) % 2) == 1) begin
      o.mux_sel    = 1'b1;
      o.dout_valid = 1'b1;
      o.dout_sof   = (idx == span);
    end else if (idx >= 2 * span) begin
      o.dout_valid = 1'b1;
      o.tw_en      = 1'b1;
      o.tw_idx     = 4'(idx % span);
    end
    return o;
  endfunction

  function automatic obs_t flush_out(input int span, input int i);
    obs_t o;
    o            = '0;
    o.dly_en     = 1'b1;
    o.busy       = 1'b1;
    o.dout_valid = 1'b1;
    o.tw_en      = 1'b1;
    o.tw_idx     = 4'(i);
    o.dout_eof   = (i == span - 1);
    return o;
  endfunction

  function automatic obs_t pack4();
    obs_t o;
    o.dly_en = dly_en4; o.mux_sel = mux_sel4; o.tw_en = tw_en4;
    o.tw_idx = {2'b00, tw_idx4}; o.dout_valid = dout_valid4;
    o.dout_sof = dout_sof4; o.dout_eof = dout_eof4; o.busy = busy4; o.err_gap = err_gap4;
    return o;
  endfunction

  function automatic obs_t pack1();
    obs_t o;
    o.dly_en = dly_en1; o.mux_sel = mux_sel1; o.tw_en = tw_en1;
    o.tw_idx = {3'b000, tw_idx1}; o.dout_valid = dout_valid1;
    o.dout_sof = dout_sof1; o.dout_eof = dout_eof1; o.busy = busy1; o.err_gap = err_gap1;
    return o;
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %03h, expected %03h", name, cyc, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, {11'b0, act}, {11'b0, exp});
  endtask

  task automatic clear_ahead();
    for (int s = 0; s < 2; s++)
      for (int m = cyc; m < cyc + 10 && m < CYC_MAX; m++)
        exp_q[s][m] = '0;
  endtask

  // Behavioural model: runs on every rising edge with the sampled inputs.
  initial begin : model
    int idx;
    forever begin
      @(posedge clk);
      cyc++;
      if (cyc + 10 >= CYC_MAX) begin
        $display("FAIL table_overflow @edge %0d: got %0d, expected < %0d", cyc, cyc, CYC_MAX - 10);
        $fatal(1, "output table exhausted");
      end
      if (!rstn) begin
        m_active = 1'b0;
        m_k      = 0;
        m_err    = 1'b0;
      end else begin
        if (din_valid) begin
          idx = m_active ? m_k : 0;
          for (int s = 0; s < 2; s++)
            exp_q[s][cyc] = obs_t'(exp_q[s][cyc] | beat_out(span_of(s), idx));
          if (idx == FB - 1) begin
            m_active = 1'b0;
            m_k      = 0;
            for (int s = 0; s < 2; s++)
              for (int i = 0; i < span_of(s); i++)
                exp_q[s][cyc + 1 + i] = obs_t'(exp_q[s][cyc + 1 + i] | flush_out(span_of(s), i));
          end else begin
            m_active = 1'b1;
            m_k      = idx + 1;
          end
          if (err_clr) m_err = 1'b0;
        end else if (m_active) begin
          // Abort: nothing comes out from here on, booked diffs are dropped.
          m_active = 1'b0;
          m_k      = 0;
          m_err    = 1'b1;
          clear_ahead();
        end else if (err_clr) begin
          m_err = 1'b0;
        end
        for (int s = 0; s < 2; s++) exp_q[s][cyc].err_gap = m_err;
      end
    end
  end

  // Compare process: every falling edge, both controllers against the table.
  initial begin : compare
    obs_t a4, a1, e4, e1;
    forever begin
      @(negedge clk);
      a4 = pack4();
      a1 = pack1();
      act4[cyc] = a4;
      act1[cyc] = a1;
      e4 = rstn ? exp_q[0][cyc] : '0;
      e1 = rstn ? exp_q[1][cyc] : '0;
      check("model_span4", a4, e4);
      check("model_span1", a1, e1);
    end
  end

  task automatic drive(input logic dv, input logic ec);
    din_valid = dv;
    err_clr   = ec;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0);
  endtask

  task automatic idle(input int n, input bit rnd_clr);
    for (int i = 0; i < n; i++)
      drive(1'b0, rnd_clr ? ($urandom_range(0, 3) == 0) : 1'b0);
  endtask

  task automatic do_reset(input int hold);
    din_valid = 1'b0;
    err_clr   = 1'b0;
    rstn      = 1'b0;
    m_active  = 1'b0;
    m_k       = 0;
    m_err     = 1'b0;
    clear_ahead();
    #1;
    check("rst_async_span4", pack4(), 12'h000);
    check("rst_async_span1", pack1(), 12'h000);
    repeat (hold) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  initial begin : stim
    int r;
    for (int s = 0; s < 2; s++)
      for (int m = 0; m < CYC_MAX; m++) exp_q[s][m] = '0;
    rstn      = 1'b0;
    din_valid = 1'b0;
    err_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    idle(3, 1'b0);

    // Single frame
    base = cyc + 1;
    frame(32);
    idle(8, 1'b0);
    for (int c = 5; c <= 36; c++) check_bit("sf_valid4", act4[pc(c)].dout_valid, 1'b1);
    check_bit("sf_valid4_pre",  act4[pc(4)].dout_valid, 1'b0);
    check_bit("sf_valid4_post", act4[pc(37)].dout_valid, 1'b0);
    check_bit("sf_sof4", act4[pc(5)].dout_sof, 1'b1);
    check_bit("sf_eof4", act4[pc(36)].dout_eof, 1'b1);
    check_bit("sf_busy4_first", act4[pc(1)].busy, 1'b1);
    check_bit("sf_busy4_last",  act4[pc(36)].busy, 1'b1);
    check_bit("sf_busy4_after", act4[pc(37)].busy, 1'b0);
    for (int run = 0; run < 4; run++)
      for (int i = 0; i < 4; i++) begin
        check_bit("sf_twen4", act4[pc(9 + 8 * run + i)].tw_en, 1'b1);
        check("sf_twidx4", {8'b0, act4[pc(9 + 8 * run + i)].tw_idx}, 12'(i));
      end
    check_bit("sf_twen4_calc", act4[pc(13)].tw_en, 1'b0);
    check_bit("sf_valid1_first", act1[pc(2)].dout_valid, 1'b1);
    check_bit("sf_valid1_pre",   act1[pc(1)].dout_valid, 1'b0);
    check_bit("sf_eof1",         act1[pc(33)].dout_eof, 1'b1);
    check_bit("sf_valid1_post",  act1[pc(34)].dout_valid, 1'b0);

    // Back-to-back frames
    base = cyc + 1;
    frame(64);
    idle(8, 1'b0);
    for (int c = 5; c <= 68; c++) check_bit("b2b_valid4", act4[pc(c)].dout_valid, 1'b1);
    check_bit("b2b_eof4_a", act4[pc(36)].dout_eof, 1'b1);
    check_bit("b2b_eof4_b", act4[pc(68)].dout_eof, 1'b1);
    check_bit("b2b_sof4_a", act4[pc(5)].dout_sof, 1'b1);
    check_bit("b2b_sof4_b", act4[pc(37)].dout_sof, 1'b1);

    // Gap at beat 10, then err_clr in cycle 15
    base = cyc + 1;
    frame(10);
    idle(5, 1'b0);
    drive(1'b0, 1'b1);
    idle(4, 1'b0);
    check_bit("gap_err",   act4[pc(11)].err_gap, 1'b1);
    check_bit("gap_valid", act4[pc(11)].dout_valid, 1'b0);
    check_bit("gap_busy",  act4[pc(11)].busy, 1'b0);
    check_bit("gap_err_held", act4[pc(15)].err_gap, 1'b1);
    check_bit("gap_err_clr",  act4[pc(16)].err_gap, 1'b0);
    for (int c = 10; c <= 16; c++) check_bit("gap_no_eof", act4[pc(c)].dout_eof, 1'b0);

    // Reset mid-frame, then a clean frame
    frame(20);
    do_reset(2);
    idle(3, 1'b0);
    base = cyc + 1;
    frame(32);
    idle(8, 1'b0);
    check_bit("post_rst_sof4", act4[pc(5)].dout_sof, 1'b1);
    check_bit("post_rst_eof4", act4[pc(36)].dout_eof, 1'b1);

    // New frame while the previous one is flushing
    base = cyc + 1;
    frame(32);
    idle(2, 1'b0);
    frame(32);
    idle(8, 1'b0);
    check_bit("fl_eof4",    act4[pc(36)].dout_eof, 1'b1);
    check_bit("fl_sof4",    act4[pc(39)].dout_sof, 1'b1);
    check_bit("fl_hole4_a", act4[pc(37)].dout_valid, 1'b0);
    check_bit("fl_hole4_b", act4[pc(38)].dout_valid, 1'b0);
    check_bit("fl_valid4",  act4[pc(35)].dout_valid, 1'b1);

    // Randomised traffic
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      if (r < 5)      frame(32);
      else if (r < 7) frame(64);
      else if (r < 9) frame($urandom_range(1, 31));
      else begin
        frame($urandom_range(1, 40));
        do_reset($urandom_range(1, 3));
      end
      idle($urandom_range(0, 6), 1'b1);
    end
    idle(10, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
